// File: rtl/vga_capture_if.sv
// Bus bundle for vga_capture: control handshake, incoming VGA stream and
// pixel-buffer write port.
interface vga_capture_if;
    logic        cap_start;
    logic        vga_hs;
    logic        vga_vs;
    logic [7:0]  vga_rgb;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        frame_done;
    logic        sync_err;

    modport master (
        output cap_start, vga_hs, vga_vs, vga_rgb,
        input  wr_en, wr_addr, wr_data, busy, frame_done, sync_err
    );

    modport slave (
        input  cap_start, vga_hs, vga_vs, vga_rgb,
        output wr_en, wr_addr, wr_data, busy, frame_done, sync_err
    );
endinterface

// File: rtl/vga_capture.sv
// Frame-capture receiver: locks to VGA sync pulses and writes a rectangular
// window of one frame into a 16-bit-addressed pixel buffer.
module vga_capture #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int X0       = 0,
    parameter int Y0       = 0,
    parameter int IMG_W    = 200,
    parameter int IMG_H    = 200
) (
    input logic          clk,
    input logic          rst,
    vga_capture_if.slave bus
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] HA_LO  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] HA_HI  = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] WX_LO  = 11'(H_SYNC + H_BACK + X0);
    localparam logic [10:0] WX_HI  = 11'(H_SYNC + H_BACK + X0 + IMG_W);
    localparam logic [9:0]  VA_LO  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  VA_HI  = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0]  WY_LO  = 10'(V_SYNC + V_BACK + Y0);
    localparam logic [9:0]  WY_HI  = 10'(V_SYNC + V_BACK + Y0 + IMG_H);
    localparam logic [15:0] A_LAST = 16'(IMG_W * IMG_H - 1);

    if (IMG_W * IMG_H > 65536 || H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_geometry
        $error("vga_capture: geometry out of range");
    end

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

    state_t      state, state_next;
    logic        s1_hs, s1_vs, s2_hs, s2_vs;
    logic [7:0]  s1_rgb, s2_rgb;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        hs_fall, vs_fall, in_win;
    logic [15:0] addr, addr_next;

    logic        wr_en_q, wr_en_n;
    logic [15:0] wr_addr_q, wr_addr_n;
    logic [7:0]  wr_data_q, wr_data_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        err_q, err_n;

    assign hs_fall = s2_hs & ~s1_hs;
    assign vs_fall = s2_vs & ~s1_vs;

    // h_cnt/v_cnt describe the pixel currently held in s2.
    assign in_win = (h_cnt >= HA_LO) && (h_cnt < HA_HI) &&
                    (h_cnt >= WX_LO) && (h_cnt < WX_HI) &&
                    (v_cnt >= VA_LO) && (v_cnt < VA_HI) &&
                    (v_cnt >= WY_LO) && (v_cnt < WY_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_rgb <= '0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
            s2_rgb <= '0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            s1_hs  <= bus.vga_hs;
            s1_vs  <= bus.vga_vs;
            s1_rgb <= bus.vga_rgb;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_rgb <= s1_rgb;
            if (hs_fall)
                h_cnt <= '0;
            else if (h_cnt != '1)
                h_cnt <= h_cnt + 11'd1;
            if (vs_fall)
                v_cnt <= '0;
            else if (hs_fall && v_cnt != '1)
                v_cnt <= v_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr_q;
        wr_data_n  = wr_data_q;
        done_n     = 1'b0;
        err_n      = err_q;
        case (state)
            IDLE: begin
                if (bus.cap_start) begin
                    state_next = ARM;
                    err_n      = 1'b0;
                end
            end
            ARM: begin
                if (vs_fall) begin
                    state_next = CAPTURE;
                    addr_next  = '0;
                end
            end
            CAPTURE: begin
                if (vs_fall || (hs_fall && h_cnt != H_LAST)) begin
                    state_next = IDLE;
                    err_n      = 1'b1;
                end else if (in_win) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = addr;
                    wr_data_n = s2_rgb;
                    addr_next = addr + 16'd1;
                    if (addr == A_LAST) begin
                        done_n     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // busy stays high through the frame_done cycle and drops one later.
        busy_n = (state_next != IDLE) || done_n;
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture: drives whole VGA frames with random
// content and compares the buffer writes against a window model.
module tb_vga_capture;
    localparam int HS = 4, HB = 4, HA = 16, HF = 4, HT = HS + HB + HA + HF;
    localparam int VS = 1, VB = 1, VA = 8, VF = 1, VT = VS + VB + VA + VF;
    localparam int X0 = 2, Y0 = 1, W = 8, H = 4, N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_capture_if bus ();

    vga_capture #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .X0(X0), .Y0(Y0), .IMG_W(W), .IMG_H(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor
    int wr_a[$];
    int wr_d[$];
    int wr_c[$];
    int ndone, done_idx, done_busy, post_busy;
    bit chk_next;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_a.push_back(int'(bus.wr_addr));
            wr_d.push_back(int'(bus.wr_data));
            wr_c.push_back(cyc);
        end
        if (chk_next) begin
            post_busy = int'(bus.busy);
            chk_next  = 1'b0;
        end
        if (bus.frame_done === 1'b1) begin
            ndone++;
            done_idx  = (bus.wr_en === 1'b1) ? wr_a.size() - 1 : -1;
            done_busy = int'(bus.busy);
            chk_next  = 1'b1;
        end
    end

    // Reference: expected data and bus-arrival cycle of each window pixel
    int exp_d[N];
    int exp_c[N];

    task automatic clear_mon();
        wr_a.delete();
        wr_d.delete();
        wr_c.delete();
        ndone     = 0;
        done_idx  = -2;
        done_busy = -1;
        post_busy = -1;
        chk_next  = 1'b0;
    endtask

    // One full frame. cap_l/cap_p place a cap_start pulse, rec records the
    // window into the model, rnd randomises active pixels, short_l drops the
    // last clock of that line, rst_at pulses reset once that many writes seen.
    task automatic drive_frame(input int cap_l, input int cap_p, input bit rec,
                               input bit rnd, input int short_l, input int rst_at);
        bit did_rst = 1'b0;
        for (int l = 0; l < VT; l++) begin
            for (int p = 0; p < HT; p++) begin
                int x, y, xr, yr;
                logic [7:0] v;
                bit cap_now;
                if (l == short_l && p == HT - 1) continue;
                x = p - HS - HB;
                y = l - VS - VB;
                xr = x - X0;
                yr = y - Y0;
                v = 8'($urandom);
                if (!rnd && x >= 0 && x < HA && y >= 0 && y < VA) v = 8'(x + 16 * y);
                cap_now = (l == cap_l && p == cap_p);
                bus.vga_hs    = (p >= HS);
                bus.vga_vs    = (l >= VS);
                bus.vga_rgb   = v;
                bus.cap_start = cap_now;
                if (rec && xr >= 0 && xr < W && yr >= 0 && yr < H) begin
                    exp_d[yr * W + xr] = int'(v);
                    exp_c[yr * W + xr] = cyc + 3;
                end
                @(posedge clk);
                #1;
                if (did_rst && rst) rst = 1'b0;
                if (cap_now) begin
                    total++;
                    if (bus.busy !== 1'b1) begin
                        bad++;
                        $display("FAIL cap_busy got=%b want=1", bus.busy);
                    end
                    total++;
                    if (bus.sync_err !== 1'b0) begin
                        bad++;
                        $display("FAIL cap_clears_err got=%b want=0", bus.sync_err);
                    end
                end
                if (rst_at > 0 && !did_rst && wr_a.size() == rst_at) begin
                    rst = 1'b1;
                    #1;
                    did_rst = 1'b1;
                    total++;
                    if ({bus.wr_en, bus.busy, bus.frame_done, bus.sync_err} !== 4'b0000 ||
                        bus.wr_addr !== 16'd0 || bus.wr_data !== 8'd0) begin
                        bad++;
                        $display("FAIL midrst_outputs got=en%b busy%b done%b err%b a%0h d%0h want=all 0",
                                 bus.wr_en, bus.busy, bus.frame_done, bus.sync_err,
                                 bus.wr_addr, bus.wr_data);
                    end
                end
            end
        end
        bus.cap_start = 1'b0;
    endtask

    task automatic test_reset();
        bus.cap_start = 1'b0;
        bus.vga_hs    = 1'b1;
        bus.vga_vs    = 1'b1;
        bus.vga_rgb   = 8'd0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b want=0", bus.wr_en); end
        total++;
        if (bus.wr_addr !== 16'd0) begin bad++; $display("FAIL rst_wr_addr got=%0h want=0", bus.wr_addr); end
        total++;
        if (bus.wr_data !== 8'd0) begin bad++; $display("FAIL rst_wr_data got=%0h want=0", bus.wr_data); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++;
        if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.frame_done); end
        total++;
        if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.sync_err); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        clear_mon();
        drive_frame(-1, -1, 1'b0, 1'b1, -1, -1);
        drive_frame(-1, -1, 1'b0, 1'b1, -1, -1);
        total++;
        if (wr_a.size() != 0) begin bad++; $display("FAIL idle_writes got=%0d want=0", wr_a.size()); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_capture();
        clear_mon();
        drive_frame(int'($urandom_range(1, VT - 1)), int'($urandom_range(0, HT - 1)),
                    1'b0, 1'b0, -1, -1);
        total++;
        if (wr_a.size() != 0) begin bad++; $display("FAIL cap_early_writes got=%0d want=0", wr_a.size()); end
        drive_frame(-1, -1, 1'b1, 1'b0, -1, -1);
        total++;
        if (wr_a.size() != N) begin bad++; $display("FAIL cap_count got=%0d want=%0d", wr_a.size(), N); end
        for (int k = 0; k < N && k < wr_a.size(); k++) begin
            total++;
            if (wr_a[k] != k || wr_d[k] != exp_d[k] || wr_c[k] != exp_c[k]) begin
                bad++;
                $display("FAIL cap_write[%0d] got=a%0d d%0h c%0d want=a%0d d%0h c%0d",
                         k, wr_a[k], wr_d[k], wr_c[k], k, exp_d[k], exp_c[k]);
            end
        end
        if (wr_a.size() == N) begin
            total++;
            if (wr_d[0] != 'h12) begin bad++; $display("FAIL cap_first_data got=%0h want=12", wr_d[0]); end
            total++;
            if (wr_d[N-1] != 'h49 || wr_a[N-1] != N - 1) begin
                bad++;
                $display("FAIL cap_last got=a%0d d%0h want=a%0d d49", wr_a[N-1], wr_d[N-1], N - 1);
            end
        end
        total++;
        if (ndone != 1 || done_idx != N - 1) begin
            bad++;
            $display("FAIL cap_done got=n%0d idx%0d want=n1 idx%0d", ndone, done_idx, N - 1);
        end
        total++;
        if (done_busy != 1 || post_busy != 0) begin
            bad++;
            $display("FAIL cap_busy_fall got=%0d,%0d want=1,0", done_busy, post_busy);
        end
        total++;
        if (bus.sync_err !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL cap_end_state got=err%b busy%b want=err0 busy0", bus.sync_err, bus.busy);
        end
    endtask

    task automatic test_same_vs();
        clear_mon();
        drive_frame(0, 1, 1'b0, 1'b1, -1, -1);
        total++;
        if (wr_a.size() != 0) begin bad++; $display("FAIL samevs_first_frame got=%0d want=0", wr_a.size()); end
        drive_frame(-1, -1, 1'b1, 1'b1, -1, -1);
        total++;
        if (wr_a.size() != N || ndone != 1) begin
            bad++;
            $display("FAIL samevs_count got=%0d/%0d want=%0d/1", wr_a.size(), ndone, N);
        end
        for (int k = 0; k < N && k < wr_a.size(); k++) begin
            total++;
            if (wr_a[k] != k || wr_d[k] != exp_d[k]) begin
                bad++;
                $display("FAIL samevs_write[%0d] got=a%0d d%0h want=a%0d d%0h", k, wr_a[k], wr_d[k], k, exp_d[k]);
            end
        end
    endtask

    task automatic test_sync_err();
        int short_l = VS + VB + Y0 + 1;
        int n_ok = (short_l - (VS + VB + Y0) + 1) * W;
        clear_mon();
        drive_frame(int'($urandom_range(1, VT - 1)), int'($urandom_range(0, HT - 1)),
                    1'b0, 1'b0, -1, -1);
        drive_frame(-1, -1, 1'b1, 1'b1, short_l, -1);
        total++;
        if (wr_a.size() != n_ok) begin bad++; $display("FAIL err_writes got=%0d want=%0d", wr_a.size(), n_ok); end
        for (int k = 0; k < n_ok && k < wr_a.size(); k++) begin
            total++;
            if (wr_a[k] != k || wr_d[k] != exp_d[k]) begin
                bad++;
                $display("FAIL err_write[%0d] got=a%0d d%0h want=a%0d d%0h", k, wr_a[k], wr_d[k], k, exp_d[k]);
            end
        end
        total++;
        if (ndone != 0) begin bad++; $display("FAIL err_no_done got=%0d want=0", ndone); end
        total++;
        if (bus.sync_err !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL err_state got=err%b busy%b want=err1 busy0", bus.sync_err, bus.busy);
        end
        clear_mon();
        drive_frame(int'($urandom_range(1, VT - 1)), int'($urandom_range(0, HT - 1)),
                    1'b0, 1'b1, -1, -1);
        drive_frame(-1, -1, 1'b1, 1'b1, -1, -1);
        total++;
        if (wr_a.size() != N || ndone != 1 || bus.sync_err !== 1'b0) begin
            bad++;
            $display("FAIL err_recover got=%0d/%0d err%b want=%0d/1 err0", wr_a.size(), ndone, bus.sync_err, N);
        end
        for (int k = 0; k < N && k < wr_a.size(); k++) begin
            total++;
            if (wr_a[k] != k || wr_d[k] != exp_d[k]) begin
                bad++;
                $display("FAIL recover_write[%0d] got=a%0d d%0h want=a%0d d%0h", k, wr_a[k], wr_d[k], k, exp_d[k]);
            end
        end
    endtask

    task automatic test_cap_in_capture();
        clear_mon();
        drive_frame(int'($urandom_range(1, VT - 1)), int'($urandom_range(0, HT - 1)),
                    1'b0, 1'b1, -1, -1);
        drive_frame(VS + VB + Y0 + 2, 3, 1'b1, 1'b1, -1, -1);
        total++;
        if (wr_a.size() != N || ndone != 1) begin
            bad++;
            $display("FAIL incap_count got=%0d/%0d want=%0d/1", wr_a.size(), ndone, N);
        end
        for (int k = 0; k < N && k < wr_a.size(); k++) begin
            total++;
            if (wr_a[k] != k || wr_d[k] != exp_d[k]) begin
                bad++;
                $display("FAIL incap_write[%0d] got=a%0d d%0h want=a%0d d%0h", k, wr_a[k], wr_d[k], k, exp_d[k]);
            end
        end
        drive_frame(-1, -1, 1'b0, 1'b1, -1, -1);
        total++;
        if (wr_a.size() != N || ndone != 1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL incap_no_rearm got=%0d/%0d busy%b want=%0d/1 busy0", wr_a.size(), ndone, bus.busy, N);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        drive_frame(int'($urandom_range(1, VT - 1)), int'($urandom_range(0, HT - 1)),
                    1'b0, 1'b1, -1, -1);
        drive_frame(-1, -1, 1'b1, 1'b1, -1, 10);
        total++;
        if (wr_a.size() != 10 || ndone != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_after got=%0d/%0d busy%b want=10/0 busy0", wr_a.size(), ndone, bus.busy);
        end
        clear_mon();
        drive_frame(int'($urandom_range(1, VT - 1)), int'($urandom_range(0, HT - 1)),
                    1'b0, 1'b1, -1, -1);
        drive_frame(-1, -1, 1'b1, 1'b1, -1, -1);
        total++;
        if (wr_a.size() != N || ndone != 1) begin
            bad++;
            $display("FAIL midrst_restart got=%0d/%0d want=%0d/1", wr_a.size(), ndone, N);
        end
        for (int k = 0; k < N && k < wr_a.size(); k++) begin
            total++;
            if (wr_a[k] != k || wr_d[k] != exp_d[k]) begin
                bad++;
                $display("FAIL restart_write[%0d] got=a%0d d%0h want=a%0d d%0h", k, wr_a[k], wr_d[k], k, exp_d[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_capture();
        test_same_vs();
        test_sync_err();
        test_cap_in_capture();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
